weight_rep_encoder: RTL

Offline-side encoder that turns a weight stream, pre-grouped by value, into the three streams the PU in-line path consumes: unique weights, repetition counts and original indices. It writes into the unique-weight, repetition and index buffers through independent valid/ready channels. It is the producer that fills the buffers the PU controller later drains, and it pulses finished after the last group is flushed.

---
 rtl/wrep_pkg.sv | 16 +
 rtl/wrep_out_slot.sv | 27 ++
 rtl/weight_rep_encoder.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/wrep_pkg.sv
// Shared state encoding and default widths for the weight repetition encoder.
`timescale 1ns/1ps
package wrep_pkg;

    localparam int WEIGHT_W_D = 8;
    localparam int IDX_W_D    = 10;
    localparam int CNT_W_D    = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } wrep_state_t;

endpackage

// File: rtl/wrep_out_slot.sv
// One-entry valid/ready output register; may reload in the cycle it drains.
`timescale 1ns/1ps
module wrep_out_slot #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] data
);

    always_ff @(posedge clock) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/weight_rep_encoder.sv
// Run-length encoder turning a value-grouped weight stream into
// unique-weight, repetition-count and index streams.
`timescale 1ns/1ps
module weight_rep_encoder
    import wrep_pkg::*;
#(
    parameter int WEIGHT_W = WEIGHT_W_D,
    parameter int IDX_W    = IDX_W_D,
    parameter int CNT_W    = CNT_W_D
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WEIGHT_W-1:0] in_weight,
    input  logic [IDX_W-1:0]    in_index,
    input  logic                in_last,
    output logic                uw_valid,
    input  logic                uw_ready,
    output logic [WEIGHT_W-1:0] uw_data,
    output logic                rep_valid,
    input  logic                rep_ready,
    output logic [CNT_W-1:0]    rep_data,
    output logic                idx_valid,
    input  logic                idx_ready,
    output logic [IDX_W-1:0]    idx_data,
    output logic                busy,
    output logic                finished,
    output logic [IDX_W:0]      unique_count
);

    localparam logic [CNT_W-1:0] MAX_REP = '1;

    wrep_state_t         state;
    logic [WEIGHT_W-1:0] cur_w;
    logic [CNT_W-1:0]    cur_cnt;
    logic                have_group;

    logic gfree;
    logic accept;
    logic same_run;
    logic close_grp;
    logic flush_load;
    logic grp_load;

    // uw and rep load as a pair, so both must have room
    assign gfree = (!uw_valid || uw_ready) && (!rep_valid || rep_ready);
    assign in_ready = (state == RUN) && (!idx_valid || idx_ready) && gfree;
    assign accept = in_valid && in_ready;
    assign same_run = (in_weight == cur_w) && (cur_cnt != MAX_REP);
    assign close_grp = accept && have_group && !same_run;
    assign flush_load = (state == FLUSH) && gfree;
    assign grp_load = close_grp || flush_load;
    assign busy = (state != IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            cur_w        <= '0;
            cur_cnt      <= '0;
            have_group   <= 1'b0;
            unique_count <= '0;
            finished     <= 1'b0;
        end else begin
            finished <= 1'b0;
            if (grp_load) begin
                unique_count <= unique_count + 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state        <= RUN;
                        cur_cnt      <= '0;
                        have_group   <= 1'b0;
                        unique_count <= '0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (!have_group || !same_run) begin
                            cur_w      <= in_weight;
                            cur_cnt    <= CNT_W'(1);
                            have_group <= 1'b1;
                        end else begin
                            cur_cnt <= cur_cnt + 1'b1;
                        end
                        if (in_last) begin
                            state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (gfree) begin
                        have_group <= 1'b0;
                        state      <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!uw_valid && !rep_valid && !idx_valid) begin
                        finished <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    wrep_out_slot #(.W(WEIGHT_W)) u_uw (
        .clock     (clock),
        .reset     (reset),
        .load      (grp_load),
        .load_data (cur_w),
        .ready     (uw_ready),
        .valid     (uw_valid),
        .data      (uw_data)
    );

    wrep_out_slot #(.W(CNT_W)) u_rep (
        .clock     (clock),
        .reset     (reset),
        .load      (grp_load),
        .load_data (cur_cnt),
        .ready     (rep_ready),
        .valid     (rep_valid),
        .data      (rep_data)
    );

    wrep_out_slot #(.W(IDX_W)) u_idx (
        .clock     (clock),
        .reset     (reset),
        .load      (accept),
        .load_data (in_index),
        .ready     (idx_ready),
        .valid     (idx_valid),
        .data      (idx_data)
    );

endmodule
